// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions used by the NIC, the router input channels and the
// router output ports.
//
// Packet header layout (bit 0 is the MSB, vectors are declared [0:N-1]):
//   [0]      vc     virtual channel / buffer index
//   [1]      xdir   0 = East,  1 = West
//   [2]      ydir   0 = North, 1 = South
//   [8:15]   hop_x  remaining X hops
//   [16:23]  hop_y  remaining Y hops
//   [32:63]  payload
//
// Route requests are one-hot {N,S,E,W,PE}. An all-zero value means "no request".
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int PACKET_WIDTH = 64;
  localparam int HOP_W        = 8;

  // Header field positions, counted from the MSB (bit 0).
  localparam int VC_BIT    = 0;
  localparam int XDIR_BIT  = 1;
  localparam int YDIR_BIT  = 2;
  localparam int HOP_X_POS = 8;
  localparam int HOP_Y_POS = 16;

  // Bit index of each direction inside a route_t.
  localparam int DIR_PE = 0;
  localparam int DIR_W  = 1;
  localparam int DIR_E  = 2;
  localparam int DIR_S  = 3;
  localparam int DIR_N  = 4;
  localparam int NUM_DIRS = 5;

  typedef logic [NUM_DIRS-1:0] route_t;

  localparam route_t ROUTE_NONE = 5'b00000;
  localparam route_t ROUTE_N    = 5'b10000;
  localparam route_t ROUTE_S    = 5'b01000;
  localparam route_t ROUTE_E    = 5'b00100;
  localparam route_t ROUTE_W    = 5'b00010;
  localparam route_t ROUTE_PE   = 5'b00001;

  // Dimension-ordered XY routing: finish X first, then Y, then eject locally.
  function automatic route_t xy_route(input logic [0:PACKET_WIDTH-1] pkt);
    route_t r;
    if (pkt[HOP_X_POS +: HOP_W] != '0) begin
      r = pkt[XDIR_BIT] ? ROUTE_W : ROUTE_E;
    end else if (pkt[HOP_Y_POS +: HOP_W] != '0) begin
      r = pkt[YDIR_BIT] ? ROUTE_S : ROUTE_N;
    end else begin
      r = ROUTE_PE;
    end
    return r;
  endfunction

endpackage

// File: rtl/ric_vc_slot.sv
// -----------------------------------------------------------------------------
// ric_vc_slot
// One single-packet virtual-channel buffer: packet register, full flag and the
// XY route computed from the packet header when it is written.
//
// Ports:
//   clk       clock, all state on posedge
//   reset     asynchronous, active-low; empties the slot
//   wr_en     write wr_data into the slot (sets full)
//   wr_data   incoming packet
//   clr       packet has been granted downstream (clears full)
//   full      slot holds a packet
//   data      stored packet
//   route     one-hot route of the stored packet
// -----------------------------------------------------------------------------
module ric_vc_slot
  import noc_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [0:PACKET_WIDTH-1] wr_data,
  input  logic                    clr,
  output logic                    full,
  output logic [0:PACKET_WIDTH-1] data,
  output logic [NUM_DIRS-1:0]     route
);

  // The top never writes and clears the same slot in one cycle (polarity
  // separates the two sides), so write simply takes priority.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full  <= 1'b0;
      // NOTE: the packet register is reset too so a dropped packet leaves no
      // stale contents; outputs are also gated by full.
      data  <= '0;
      route <= ROUTE_NONE;
    end else if (wr_en) begin
      full  <= 1'b1;
      data  <= wr_data;
      route <= xy_route(wr_data);
    end else if (clr) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/router_input_channel.sv
// -----------------------------------------------------------------------------
// router_input_channel
// Router-side receiver for one link. Terminates the si/ri handshake from a NIC
// or neighbour router, holds two single-packet VC buffers (even/odd) and
// presents one XY-routed packet per cycle to the switch allocator.
//
// The global polarity bit picks which buffer each side uses: the external
// (upstream) side uses buf[polarity], the internal (allocator) side uses
// buf[~polarity], so the two never touch the same buffer in one cycle.
//
// Parameters:
//   PACKET_WIDTH  packet width, must match noc_pkg
//   HOP_W         hop-count field width, must match noc_pkg
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-low; clears all state
//   polarity    router-global polarity, toggles every cycle
//   in_si       upstream send strobe
//   in_ri       ready to upstream
//   in_di       upstream packet (bit 0 = MSB)
//   out_req     one-hot route request {N,S,E,W,PE}; zero = no request
//   out_gnt     allocator grant for the current out_req
//   perf_pkts   (RIC_PERF_CNT_EN) accepted packets, saturating
//   perf_stall  (RIC_PERF_CNT_EN) cycles requesting without grant, saturating
//   out_do      forwarded packet: routed hop field decremented, vc = buffer
//
// Optional feature: define RIC_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module router_input_channel #(
  parameter int PACKET_WIDTH = 64,
  parameter int HOP_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    polarity,
  input  logic                    in_si,
  output logic                    in_ri,
  input  logic [0:PACKET_WIDTH-1] in_di,
  output logic [4:0]              out_req,
  input  logic                    out_gnt,
`ifdef RIC_PERF_CNT_EN
  output logic [15:0]             perf_pkts,
  output logic [15:0]             perf_stall,
`endif
  output logic [0:PACKET_WIDTH-1] out_do
);

  localparam logic [HOP_W-1:0] HOP_ONE = 1;

  logic                    rd_sel;
  logic                    accept;
  logic                    grant;
  logic [1:0]              wr_en;
  logic [1:0]              clr;
  logic [1:0]              full;
  logic [0:PACKET_WIDTH-1] slot_data  [2];
  logic [4:0]              slot_route [2];
  logic [0:PACKET_WIDTH-1] rd_data;
  logic [4:0]              rd_route;

  assign rd_sel = ~polarity;

  // Ready is held low during reset even though the flags are already clear.
  assign in_ri  = reset & ~full[polarity];
  assign accept = in_si & in_ri;
  // A grant only counts while something is actually being requested.
  assign grant  = out_gnt & (out_req != 5'b00000);

  assign wr_en[0] = accept & ~polarity;
  assign wr_en[1] = accept &  polarity;
  assign clr[0]   = grant  &  rd_sel == 1'b0;
  assign clr[1]   = grant  &  rd_sel == 1'b1;

  for (genvar v = 0; v < 2; v++) begin : g_slot
    ric_vc_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[v]),
      .wr_data (in_di),
      .clr     (clr[v]),
      .full    (full[v]),
      .data    (slot_data[v]),
      .route   (slot_route[v])
    );
  end

  assign rd_data  = slot_data[rd_sel];
  assign rd_route = slot_route[rd_sel];

  // The route was fixed at accept time and guarantees the decremented field
  // is non-zero, so the decrement never wraps.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    out_req = noc_pkg::ROUTE_NONE;
    out_do  = '0;
    if (full[rd_sel]) begin
      out_req = rd_route;
      out_do  = rd_data;
      out_do[noc_pkg::VC_BIT] = rd_sel;
      if (rd_route[noc_pkg::DIR_E] | rd_route[noc_pkg::DIR_W]) begin
        out_do[noc_pkg::HOP_X_POS +: HOP_W] =
          rd_data[noc_pkg::HOP_X_POS +: HOP_W] - HOP_ONE;
      end else if (rd_route[noc_pkg::DIR_N] | rd_route[noc_pkg::DIR_S]) begin
        out_do[noc_pkg::HOP_Y_POS +: HOP_W] =
          rd_data[noc_pkg::HOP_Y_POS +: HOP_W] - HOP_ONE;
      end
    end
  end

`ifdef RIC_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_pkts  <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && perf_pkts != 16'hFFFF) begin
        perf_pkts <= perf_pkts + 16'd1;
      end
      if (out_req != 5'b00000 && !out_gnt && perf_stall != 16'hFFFF) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_input_channel.sv
module tb_router_input_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        in_si;
  logic        in_ri;
  logic [0:63] in_di;
  logic [4:0]  out_req;
  logic        out_gnt;
  logic [0:63] out_do;
`ifdef RIC_PERF_CNT_EN
  logic [15:0] perf_pkts;
  logic [15:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  router_input_channel #(.PACKET_WIDTH(64), .HOP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .polarity   (polarity),
    .in_si      (in_si),
    .in_ri      (in_ri),
    .in_di      (in_di),
    .out_req    (out_req),
    .out_gnt    (out_gnt),
`ifdef RIC_PERF_CNT_EN
    .perf_pkts  (perf_pkts),
    .perf_stall (perf_stall),
`endif
    .out_do     (out_do)
  );

  // Build a packet with bit 0 = MSB field layout.
  function automatic logic [0:63] mk_pkt(input logic vc, input logic xd, input logic yd,
                                         input logic [7:0] hx, input logic [7:0] hy,
                                         input logic [31:0] pl);
    logic [0:63] p;
    p        = '0;
    p[0]     = vc;
    p[1]     = xd;
    p[2]     = yd;
    p[8:15]  = hx;
    p[16:23] = hy;
    p[32:63] = pl;
    return p;
  endfunction

  // One clock: polarity toggles just after the edge, then outputs settle.
  task automatic cyc();
    @(posedge clk);
    #1 polarity = ~polarity;
    #1;
  endtask

  task automatic align(input logic p);
    if (polarity !== p) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0; polarity = 1'b0; in_si = 1'b0; out_gnt = 1'b0; in_di = '0;
    cyc(); cyc();
    checks++; if (in_ri !== 1'b0) begin errors++; $display("FAIL reset_in_ri: got %b want 0", in_ri); end
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL reset_out_req: got %b want 00000", out_req); end
    checks++; if (out_do !== 64'h0) begin errors++; $display("FAIL reset_out_do: got %h want 0", out_do); end
    reset = 1'b1;
    align(1'b0);
    in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 32'h0BAD0BAD);
    cyc();
    in_si = 1'b0;
    // Packet is now visible; drop reset mid-transfer.
    reset = 1'b0;
    #1;
    checks++; if (in_ri !== 1'b0) begin errors++; $display("FAIL midreset_in_ri: got %b want 0", in_ri); end
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL midreset_out_req: got %b want 00000", out_req); end
    checks++; if (out_do !== 64'h0) begin errors++; $display("FAIL midreset_out_do: got %h want 0", out_do); end
    cyc();
    reset = 1'b1;
    cyc();
    checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL release_in_ri: got %b want 1", in_ri); end
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL release_dropped: got %b want 00000", out_req); end
  endtask

  task automatic test_route_w();
    align(1'b0);
    in_si = 1'b1; in_di = mk_pkt(1'b1, 1'b1, 1'b0, 8'd3, 8'd5, 32'hCAFE0001);
    cyc();
    in_si = 1'b0;
    checks++; if (out_req !== 5'b00010) begin errors++; $display("FAIL w_req: got %b want 00010", out_req); end
    checks++;
    if (out_do !== mk_pkt(1'b0, 1'b1, 1'b0, 8'd2, 8'd5, 32'hCAFE0001)) begin
      errors++; $display("FAIL w_out_do: got %h want %h", out_do, mk_pkt(1'b0, 1'b1, 1'b0, 8'd2, 8'd5, 32'hCAFE0001));
    end
    out_gnt = 1'b1;
    cyc();
    out_gnt = 1'b0;
    checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL w_gnt_free: got %b want 1", in_ri); end
    cyc();
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL w_gnt_clear: got %b want 00000", out_req); end
  endtask

  task automatic test_route_pe_n();
    align(1'b1);
    in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 32'h12345678);
    cyc();
    checks++; if (out_req !== 5'b00001) begin errors++; $display("FAIL pe_req: got %b want 00001", out_req); end
    checks++;
    if (out_do !== mk_pkt(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'h12345678)) begin
      errors++; $display("FAIL pe_out_do: got %h want %h", out_do, mk_pkt(1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 32'h12345678));
    end
    // Grant buf1 and accept into buf0 in the same cycle.
    out_gnt = 1'b1;
    in_di = mk_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 32'hA5A5A5A5);
    cyc();
    in_si = 1'b0;
    checks++; if (out_req !== 5'b10000) begin errors++; $display("FAIL n_req: got %b want 10000", out_req); end
    checks++;
    if (out_do !== mk_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 32'hA5A5A5A5)) begin
      errors++; $display("FAIL n_out_do: got %h want %h", out_do, mk_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 32'hA5A5A5A5));
    end
    cyc();
    out_gnt = 1'b0;
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL pe_n_drain: got %b want 00000", out_req); end
    checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL pe_n_free: got %b want 1", in_ri); end
  endtask

  task automatic test_stall();
    align(1'b0);
    in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b0, 1'b1, 8'd0, 8'd4, 32'hDEAD0004);
    cyc();
    for (int i = 0; i < 6; i++) begin
      if (polarity) begin
        in_si = 1'b0; out_gnt = 1'b0;
        checks++; if (out_req !== 5'b01000) begin errors++; $display("FAIL stall_req%0d: got %b want 01000", i, out_req); end
      end else begin
        checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL stall_idle%0d: got %b want 00000", i, out_req); end
        checks++; if (in_ri !== 1'b0) begin errors++; $display("FAIL stall_ri%0d: got %b want 0", i, in_ri); end
        // Both must be ignored: upstream blocked, grant without request.
        in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b0, 1'b0, 8'd7, 8'd7, 32'hBBBBBBBB);
        out_gnt = 1'b1;
      end
      cyc();
    end
    in_si = 1'b0; out_gnt = 1'b0;
    checks++;
    if (out_do !== mk_pkt(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 32'hDEAD0004)) begin
      errors++; $display("FAIL stall_held: got %h want %h", out_do, mk_pkt(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 32'hDEAD0004));
    end
    out_gnt = 1'b1;
    cyc();
    out_gnt = 1'b0;
    checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", in_ri); end
  endtask

  task automatic test_back_to_back();
    logic [0:63] pkts [8];
    logic        acc_pol [8];
    logic [0:63] exp_do;
    logic [4:0]  exp_req;
    int          i;
    for (int n = 0; n < 8; n++) begin
      pkts[n] = mk_pkt(1'b0, n[0], 1'b0, (n % 3 == 0) ? 8'd2 : 8'd0,
                       (n % 3 == 1) ? 8'd1 : 8'd0, 32'h1000 + n);
    end
    align(1'b0);
    for (int k = 0; k <= 8; k++) begin
      out_gnt = 1'b1;
      if (k < 8) begin
        in_si = 1'b1; in_di = pkts[k]; acc_pol[k] = polarity;
        checks++; if (in_ri !== 1'b1) begin errors++; $display("FAIL b2b_ri%0d: got %b want 1", k, in_ri); end
      end else begin
        in_si = 1'b0;
      end
      if (k > 0) begin
        i = k - 1;
        case (i % 3)
          0:       begin exp_req = i[0] ? 5'b00010 : 5'b00100;
                         exp_do  = mk_pkt(acc_pol[i], i[0], 1'b0, 8'd1, 8'd0, 32'h1000 + i); end
          1:       begin exp_req = 5'b10000;
                         exp_do  = mk_pkt(acc_pol[i], i[0], 1'b0, 8'd0, 8'd0, 32'h1000 + i); end
          default: begin exp_req = 5'b00001;
                         exp_do  = mk_pkt(acc_pol[i], i[0], 1'b0, 8'd0, 8'd0, 32'h1000 + i); end
        endcase
        checks++; if (out_req !== exp_req) begin errors++; $display("FAIL b2b_req%0d: got %b want %b", i, out_req, exp_req); end
        checks++; if (out_do !== exp_do) begin errors++; $display("FAIL b2b_do%0d: got %h want %h", i, out_do, exp_do); end
      end
      cyc();
    end
    out_gnt = 1'b0;
    checks++; if (out_req !== 5'b0) begin errors++; $display("FAIL b2b_empty: got %b want 00000", out_req); end
  endtask

`ifdef RIC_PERF_CNT_EN
  task automatic test_perf();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    out_gnt = 1'b1;
    for (int n = 0; n < 3; n++) begin
      in_si = 1'b1; in_di = mk_pkt(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'h77 + n);
      cyc();
    end
    in_si = 1'b0;
    cyc();
    out_gnt = 1'b0;
    checks++; if (perf_pkts !== 16'd3) begin errors++; $display("FAIL perf_pkts: got %0d want 3", perf_pkts); end
    checks++; if (perf_stall !== 16'd0) begin errors++; $display("FAIL perf_stall0: got %0d want 0", perf_stall); end
    // Fill both buffers so a request is raised every cycle, never granted.
    in_si = 1'b1; cyc(); cyc();
    in_si = 1'b0;
    repeat (70000) cyc();
    checks++; if (perf_stall !== 16'hFFFF) begin errors++; $display("FAIL perf_stall_sat: got %h want FFFF", perf_stall); end
    checks++; if (perf_pkts !== 16'd5) begin errors++; $display("FAIL perf_pkts5: got %0d want 5", perf_pkts); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_route_w();
    test_route_pe_n();
    test_stall();
    test_back_to_back();
`ifdef RIC_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
